// File: rtl/mole_game_pkg.sv
// mole_game_pkg
//   Shared types and helpers for the whack-a-mole round scheduler.
//   - state_e  : round phase (IDLE, LEAD, ACTIVE, TAIL, DONE)
//   - LVL_*    : scoring level codes driven on `level`
//   - UCW      : width of the unit (tick) counter
//   - next_idx : no-repeat rule for consecutive mole indices
package mole_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_ACTIVE,
    ST_TAIL,
    ST_DONE
  } state_e;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_1    = 2'd1;
  localparam logic [1:0] LVL_2    = 2'd2;
  localparam logic [1:0] LVL_3    = 2'd3;

  localparam int unsigned UCW = 4;

  // A repeat of the previous mole is bumped to the next LED (wrapping 7 -> 0).
  function automatic logic [2:0] next_idx(input logic [2:0] rnd, input logic [2:0] prev);
    return (rnd == prev) ? rnd + 3'd1 : rnd;
  endfunction

endpackage

// File: rtl/mole_game_sequencer_tick_prescaler.sv
// tick_prescaler
//   Free-running divider producing a one-cycle `tick` every TICK enabled cycles.
//   The count is held at zero while `en` is low, so enabling it always starts a
//   fresh period. `tick` is registered: it is high in the cycle after the count
//   reached TICK-1.
//   Ports:
//     clk   in  : system clock
//     reset in  : async, active-high
//     en    in  : count enable; low forces the count back to zero
//     tick  out : one-cycle strobe per TICK enabled cycles
module tick_prescaler #(
  parameter int unsigned TICK = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK - 1);

  if (TICK == 0) begin : g_bad_tick
    $error("tick_prescaler: TICK must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en) begin
      tick_d = (cnt_q == LAST);
      cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/mole_game_sequencer.sv
// mole_game_sequencer
//   Round scheduler for the whack-a-mole game. After `start` it waits LEAD
//   units, issues N1+N2+N3 pops separated by a level-dependent gap, waits TAIL
//   units after the last pop and then strobes `clear`. One unit is TICK clocks.
//   Ports:
//     clk       in     : system clock
//     reset     in     : async, active-high; returns to IDLE, outputs zero
//     start     in     : begin a round (honoured only in IDLE/DONE)
//     rnd       in [3] : random mole index, used on pop cycles
//     pop       out    : one-cycle strobe, a mole appears
//     pop_idx   out [3]: mole index, held between pops
//     level     out [2]: scoring level of the latest pop, 0 before the first
//     clear     out    : one-cycle strobe, blank the LEDs
//     running   out    : high in LEAD, ACTIVE and TAIL
//     done      out    : high in DONE
//     pops_left out [5]: pops remaining in the round
module mole_game_sequencer
  import mole_game_pkg::*;
#(
  parameter int unsigned TICK = 100000000,
  parameter int unsigned LEAD = 1,
  parameter int unsigned N1   = 8,
  parameter int unsigned N2   = 8,
  parameter int unsigned N3   = 8,
  parameter int unsigned G1   = 3,
  parameter int unsigned G2   = 2,
  parameter int unsigned G3   = 1,
  parameter int unsigned TAIL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] rnd,
  output logic       pop,
  output logic [2:0] pop_idx,
  output logic [1:0] level,
  output logic       clear,
  output logic       running,
  output logic       done,
  output logic [4:0] pops_left
);

  localparam int unsigned UMAX = (1 << UCW) - 1;
  localparam int unsigned NTOT = N1 + N2 + N3;

  if (G1 == 0 || G2 == 0 || G3 == 0 || LEAD == 0 || TAIL == 0 ||
      G1 > UMAX || G2 > UMAX || G3 > UMAX || LEAD > UMAX || TAIL > UMAX) begin : g_bad_timing
    $error("mole_game_sequencer: G1/G2/G3/LEAD/TAIL must be in 1..15");
  end
  if (NTOT == 0 || NTOT > 31) begin : g_bad_count
    $error("mole_game_sequencer: N1+N2+N3 must be in 1..31");
  end

  localparam logic [4:0]     NTOT_W    = 5'(NTOT);
  localparam logic [4:0]     N3_W      = 5'(N3);
  localparam logic [4:0]     N23_W     = 5'(N2 + N3);
  localparam logic [UCW-1:0] LEAD_LAST = UCW'(LEAD - 1);
  localparam logic [UCW-1:0] TAIL_LAST = UCW'(TAIL - 1);
  localparam logic [UCW-1:0] G1_LAST   = UCW'(G1 - 1);
  localparam logic [UCW-1:0] G2_LAST   = UCW'(G2 - 1);
  localparam logic [UCW-1:0] G3_LAST   = UCW'(G3 - 1);

  state_e         state_q, state_d;
  logic           pop_q, pop_d;
  logic           clear_q, clear_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic [1:0]     level_q, level_d;
  logic [2:0]     idx_q, idx_d;
  logic [4:0]     left_q, left_d;
  logic [UCW-1:0] unit_q, unit_d;

  logic           tick;
  logic [4:0]     remain_after;
  logic [1:0]     pop_level;
  logic [UCW-1:0] gap_last;

  tick_prescaler #(
    .TICK(TICK)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (running_q),
    .tick (tick)
  );

  // Level is decided by how many pops remain after this one: the last N3 are
  // level 3, the N2 before them level 2, everything earlier level 1.
  always_comb begin
    remain_after = left_q - 5'd1;
    if (remain_after < N3_W) begin
      pop_level = LVL_3;
    end else if (remain_after < N23_W) begin
      pop_level = LVL_2;
    end else begin
      pop_level = LVL_1;
    end
  end

  // The gap after a pop follows that pop's level, which is level_q here.
  always_comb begin
    case (level_q)
      LVL_1:   gap_last = G1_LAST;
      LVL_2:   gap_last = G2_LAST;
      default: gap_last = G3_LAST;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pop_d   = 1'b0;
    clear_d = 1'b0;
    level_d = level_q;
    idx_d   = idx_q;
    left_d  = left_q;
    unit_d  = tick ? unit_q + UCW'(1) : unit_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LEAD;
          unit_d  = '0;
          level_d = LVL_NONE;
          left_d  = NTOT_W;
        end
      end
      ST_LEAD: begin
        if (tick && unit_q == LEAD_LAST) begin
          pop_d   = 1'b1;
          left_d  = remain_after;
          level_d = pop_level;
          idx_d   = rnd;
          unit_d  = '0;
          state_d = (remain_after == '0) ? ST_TAIL : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (tick && unit_q == gap_last) begin
          pop_d   = 1'b1;
          left_d  = remain_after;
          level_d = pop_level;
          idx_d   = next_idx(rnd, idx_q);
          unit_d  = '0;
          state_d = (remain_after == '0) ? ST_TAIL : ST_ACTIVE;
        end
      end
      ST_TAIL: begin
        if (tick && unit_q == TAIL_LAST) begin
          clear_d = 1'b1;
        end
        // Leave TAIL only once the clear strobe is on the output, so `running`
        // covers the clear cycle and `done` rises the cycle after it.
        if (clear_q) begin
          state_d = ST_DONE;
          unit_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_LEAD) || (state_d == ST_ACTIVE) || (state_d == ST_TAIL);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pop_q     <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      level_q   <= LVL_NONE;
      idx_q     <= '0;
      left_q    <= '0;
      unit_q    <= '0;
    end else begin
      state_q   <= state_d;
      pop_q     <= pop_d;
      clear_q   <= clear_d;
      running_q <= running_d;
      done_q    <= done_d;
      level_q   <= level_d;
      idx_q     <= idx_d;
      left_q    <= left_d;
      unit_q    <= unit_d;
    end
  end

  assign pop       = pop_q;
  assign pop_idx   = idx_q;
  assign level     = level_q;
  assign clear     = clear_q;
  assign running   = running_q;
  assign done      = done_q;
  assign pops_left = left_q;

endmodule

// File: tb/tb_mole_game_sequencer.sv
module tb_mole_game_sequencer;

  localparam int TICK_P = 4;
  localparam int LEAD_P = 1;
  localparam int N1_P   = 2;
  localparam int N2_P   = 2;
  localparam int N3_P   = 2;
  localparam int G1_P   = 3;
  localparam int G2_P   = 2;
  localparam int G3_P   = 1;
  localparam int TAIL_P = 1;
  localparam int NTOT_P = N1_P + N2_P + N3_P;
  localparam int NC     = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] rnd;
  logic       pop;
  logic [2:0] pop_idx;
  logic [1:0] level;
  logic       clear;
  logic       running;
  logic       done;
  logic [4:0] pops_left;

  mole_game_sequencer #(
    .TICK(TICK_P), .LEAD(LEAD_P),
    .N1(N1_P), .N2(N2_P), .N3(N3_P),
    .G1(G1_P), .G2(G2_P), .G3(G3_P),
    .TAIL(TAIL_P)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rnd      (rnd),
    .pop      (pop),
    .pop_idx  (pop_idx),
    .level    (level),
    .clear    (clear),
    .running  (running),
    .done     (done),
    .pops_left(pops_left)
  );

  always #5 clk = ~clk;

  // Packed observation: {pop, clear, running, done, level[1:0], left[4:0], idx[2:0]}
  typedef struct packed {
    logic       pop;
    logic       clear;
    logic       running;
    logic       done;
    logic [1:0] level;
    logic [4:0] left;
    logic [2:0] idx;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t want;
  } vec_t;

  obs_t       tr[NC];
  obs_t       ex[NC];
  logic [2:0] rnd_tr[NC];
  vec_t       tbl[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic obs_t sample();
    obs_t o;
    o.pop     = pop;
    o.clear   = clear;
    o.running = running;
    o.done    = done;
    o.level   = level;
    o.left    = pops_left;
    o.idx     = pop_idx;
    return o;
  endfunction

  function automatic vec_t mk(input int c, input bit p, input bit cl, input bit rn,
                              input bit dn, input int lv, input int lf, input int ix);
    vec_t v;
    v.cyc          = c;
    v.want.pop     = p;
    v.want.clear   = cl;
    v.want.running = rn;
    v.want.done    = dn;
    v.want.level   = 2'(lv);
    v.want.left    = 5'(lf);
    v.want.idx     = 3'(ix);
    return v;
  endfunction

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, want);
    end
  endtask

  // Pulse start so that the next rising edge (cycle 0 of the round) samples it.
  task automatic start_round();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Record n cycles, sampling 1 ns after each edge. fixed_rnd < 0 selects a
  // random rnd each cycle; busy_start pulses start in that cycle; rand_starts
  // sprinkles start pulses over cycles where the round is still busy.
  task automatic capture(input int n, input int fixed_rnd, input int busy_start,
                         input bit rand_starts);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      tr[k]     = sample();
      rnd       = (fixed_rnd < 0) ? 3'($urandom_range(0, 7)) : 3'(fixed_rnd);
      rnd_tr[k] = rnd;
      start     = (k == busy_start) ||
                  (rand_starts && k >= 1 && k <= 52 && $urandom_range(0, 3) == 0);
    end
    start = 1'b0;
  endtask

  function automatic int gap_of(input int lv);
    return (lv == 1) ? G1_P : (lv == 2) ? G2_P : G3_P;
  endfunction

  // Reference schedule from the round rules: pop times are accumulated gap
  // sums, levels come from the pop ordinal, the mole index is the rnd value
  // seen at the edge raising pop, bumped by one (mod 8) on a repeat.
  task automatic build_model(input logic [2:0] idx0);
    int         pc[NTOT_P];
    int         lv[NTOT_P];
    logic [2:0] ix[NTOT_P];
    int         t;
    int         clr;
    int         popped;
    bit         isp;
    logic [2:0] r;
    t   = LEAD_P * TICK_P + 1;
    clr = 0;
    for (int k = 0; k < NTOT_P; k++) begin
      lv[k] = (k < N1_P) ? 1 : (k < N1_P + N2_P) ? 2 : 3;
      pc[k] = t;
      r     = rnd_tr[t - 1];
      if (k == 0) ix[k] = r;
      else        ix[k] = (r == ix[k-1]) ? 3'((int'(r) + 1) % 8) : r;
      if (k < NTOT_P - 1) t = t + gap_of(lv[k]) * TICK_P;
      else                clr = t + TAIL_P * TICK_P;
    end
    for (int n = 0; n < NC; n++) begin
      popped = 0;
      isp    = 1'b0;
      for (int k = 0; k < NTOT_P; k++) begin
        if (pc[k] <= n) popped++;
        if (pc[k] == n) isp = 1'b1;
      end
      ex[n].pop     = isp;
      ex[n].clear   = (n == clr);
      ex[n].running = (n <= clr);
      ex[n].done    = (n > clr);
      ex[n].level   = (popped == 0) ? 2'd0 : 2'(lv[popped-1]);
      ex[n].left    = 5'(NTOT_P - popped);
      ex[n].idx     = (popped == 0) ? idx0 : ix[popped-1];
    end
  endtask

  task automatic compare_model(input string tag);
    for (int k = 0; k < NC; k++) begin
      check(tag, k, 32'(tr[k]), 32'(ex[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         pops;
    logic [2:0] prev_idx;

    // Nominal round, rnd held at 3, start pulsed again while busy.
    tbl.push_back(mk( 0, 0, 0, 1, 0, 0, 6, 0));
    tbl.push_back(mk( 4, 0, 0, 1, 0, 0, 6, 0));
    tbl.push_back(mk( 5, 1, 0, 1, 0, 1, 5, 3));
    tbl.push_back(mk( 6, 0, 0, 1, 0, 1, 5, 3));
    tbl.push_back(mk(16, 0, 0, 1, 0, 1, 5, 3));
    tbl.push_back(mk(17, 1, 0, 1, 0, 1, 4, 4));
    tbl.push_back(mk(21, 0, 0, 1, 0, 1, 4, 4));
    tbl.push_back(mk(29, 1, 0, 1, 0, 2, 3, 3));
    tbl.push_back(mk(37, 1, 0, 1, 0, 2, 2, 4));
    tbl.push_back(mk(45, 1, 0, 1, 0, 3, 1, 3));
    tbl.push_back(mk(48, 0, 0, 1, 0, 3, 1, 3));
    tbl.push_back(mk(49, 1, 0, 1, 0, 3, 0, 4));
    tbl.push_back(mk(52, 0, 0, 1, 0, 3, 0, 4));
    tbl.push_back(mk(53, 0, 1, 1, 0, 3, 0, 4));
    tbl.push_back(mk(54, 0, 0, 0, 1, 3, 0, 4));
    tbl.push_back(mk(59, 0, 0, 0, 1, 3, 0, 4));

    reset = 1'b1;
    start = 1'b0;
    rnd   = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 0, 32'(sample()), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", 0, 32'(sample()), 32'd0);

    start_round();
    capture(NC, 3, 20, 1'b0);
    foreach (tbl[i]) begin
      check("nominal_table", tbl[i].cyc, 32'(tr[tbl[i].cyc]), 32'(tbl[i].want));
    end
    pops = 0;
    for (int k = 0; k < NC; k++) if (tr[k].pop) pops++;
    check("nominal_pop_count", NC, 32'(pops), 32'(NTOT_P));
    build_model(3'd0);
    compare_model("nominal_model");
    prev_idx = ex[NC-1].idx;

    // Restart straight from DONE (sampled at global edge 60), rnd held at 7.
    start_round();
    capture(NC, 7, -1, 1'b0);
    check("restart_done_low", 61, 32'(tr[1].done), 32'd0);
    for (int k = 1; k <= 4; k++) check("restart_level_zero", 60 + k, 32'(tr[k].level), 32'd0);
    check("restart_first_pop", 65, 32'(tr[5].pop), 32'd1);
    check("restart_first_idx", 65, 32'(tr[5].idx), 32'd7);
    check("norepeat_wrap_idx", 77, 32'(tr[17].idx), 32'd0);
    build_model(prev_idx);
    compare_model("restart_model");
    prev_idx = ex[NC-1].idx;

    // Random rnd and random start pulses while busy.
    for (int r = 0; r < 4; r++) begin
      start_round();
      capture(NC, -1, -1, 1'b1);
      build_model(prev_idx);
      compare_model("random_model");
      prev_idx = ex[NC-1].idx;
    end

    // Reset in the middle of a round.
    start_round();
    capture(31, 5, -1, 1'b0);
    check("pre_reset_pop29", 29, 32'(tr[29].pop), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_clears", 30, 32'(sample()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    capture(10, 5, -1, 1'b0);
    for (int k = 0; k < 10; k++) check("post_reset_quiet", 31 + k, 32'(tr[k]), 32'd0);
    start_round();
    capture(8, 2, -1, 1'b0);
    check("post_reset_no_early_pop", 4, 32'(tr[4].pop), 32'd0);
    check("post_reset_first_pop", 5, 32'(tr[5].pop), 32'd1);
    check("post_reset_first_idx", 5, 32'(tr[5].idx), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_game_sequencer.md
# mole_game_sequencer

Round scheduler for the whack-a-mole game. It owns game timing and decides when a mole pops, which LED it uses, and which scoring level applies. It drives the LED/score datapath through a one-cycle `pop` strobe with `pop_idx`/`level`, and ends the round with a `clear` strobe. It replaces the hard-coded timestamp compare chain with a parameterised phase machine and a shared tick prescaler.

## Interface
Parameters:
- `TICK`, default 100000000: clock cycles per time unit.
- `LEAD`, default 1: units from start to the first pop.
- `N1` / `N2` / `N3`, default 8 / 8 / 8: pops issued at level 1 / 2 / 3.
- `G1` / `G2` / `G3`, default 3 / 2 / 1: units from a level-1 / 2 / 3 pop to the next pop.
- `TAIL`, default 1: units from the last pop to `clear`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: async, active-high; returns the block to IDLE.
- `start` in 1: request a new round. Level-sensitive and sampled each cycle. A one-cycle pulse is enough.
- `rnd` in 3: random mole index from the LFSR, sampled only on pop cycles.
- `pop` out 1: one-cycle strobe; a mole appears.
- `pop_idx` out 3: mole index; valid and held from `pop` until the next `pop`.
- `level` out 2: scoring weight; 0 before the first pop, then 1/2/3.
- `clear` out 1: one-cycle strobe; the datapath blanks the LEDs.
- `running` out 1: high in LEAD, ACTIVE and TAIL.
- `done` out 1: high in DONE.
- `pops_left` out 5: pops remaining in the round.

## Operation
States: IDLE, LEAD, ACTIVE, TAIL, DONE.
- **IDLE / DONE**
  - `start`=1 → LEAD.
  - On entering LEAD: prescaler count=0, unit count=0, `level`=0, `pops_left`=N1+N2+N3.
- **LEAD**
  - Counts LEAD ticks.
  - On the completing tick: issue a pop and go to ACTIVE.
- **ACTIVE**
  - Wait G(current level) ticks after each pop, then issue the next pop.
  - After the pop that makes `pops_left`=0, go to TAIL.
- **TAIL**
  - Counts TAIL ticks.
  - On the completing tick: `clear`=1, go to DONE.
- **Issuing a pop** (all in the same cycle):
  - `pop`=1.
  - `pops_left` decrements.
  - `level` = 1 for pops 1..N1, 2 for the next N2, 3 for the last N3.
  - `pop_idx` = `rnd`, except when `rnd` equals the previous `pop_idx`: then `pop_idx` = `rnd`+1 (mod 8). This rule does not apply to the first pop of a round.
- **Gap selection:** the gap following a pop uses the level of that pop. The L1→L2 transition gap is therefore G1.
- `start` is ignored in LEAD, ACTIVE and TAIL. There is no abort other than `reset`.
- **Unit counter:** the same prescaler tick drives LEAD, gap and TAIL counting. The unit counter is cleared on every phase change and every pop.
- **Widths:**
  - Prescaler width: $clog2(TICK).
  - Unit counter: 4 bits, so every gap, LEAD and TAIL value must be ≤15.
  - N1+N2+N3 must be ≤31; elaboration fails otherwise.
- A zero-valued G, LEAD or TAIL is illegal; elaboration fails.

## Timing
- **Reset values:**
  - State IDLE.
  - `pop`=0, `clear`=0, `running`=0, `done`=0, `level`=0, `pop_idx`=0, `pops_left`=0.
  - Prescaler = 0.
- All outputs are registered.
- **Start latency:** `start` sampled at edge E → `running`=1 after E. `done` falls at the same edge.
- **Prescaler:**
  - Tick asserts in the cycle the count equals TICK-1, then the count wraps to 0.
  - It runs only while `running`=1.
- **Pop and clear placement:**
  - The first `pop` is high in cycle E+LEAD·TICK+1.
  - Consecutive pops are exactly G·TICK cycles apart.
  - `clear` comes TAIL·TICK cycles after the last pop.
  - `done`=1 in the cycle after `clear`.
- `reset` mid-round clears all outputs immediately. A `pop` or `clear` strobe in flight is lost.
- `start` held continuously in DONE restarts the round on the next edge.

## Structure
- **`mole_game_pkg`:**
  - State enum.
  - Level constants LVL_NONE/1/2/3.
  - Unit-counter width.
  - Function `next_idx(rnd, prev)` implementing the no-repeat rule.
- **Sub-module `tick_prescaler`:**
  - Parameter TICK.
  - Ports: clk, reset, en, tick.
  - Count resets to 0 when `en`=0.
  - Reusable by the debouncer/7-segment blocks.

## Test plan
Use TICK=4, LEAD=1, N1=N2=N3=2, G1=3, G2=2, G3=1, TAIL=1; `start` pulsed at edge E0 (cycle 0).
- **Nominal round:**
  - `pop` at cycles 5, 17, 29, 37, 45, 49.
  - `level` 1, 1, 2, 2, 3, 3 at those cycles.
  - `pops_left` 5..0.
  - `clear` at 53; `done`=1 from 54; `running`=0 from 54.
- **No-repeat rule:** hold `rnd`=3 throughout → `pop_idx` = 3, 4, 3, 4, 3, 4. With `rnd`=7 repeated, the next value is 0 (wrap).
- **Start while busy:** pulse `start` at cycle 20 → pop schedule identical to the nominal round.
- **Reset mid-round:** assert `reset` at cycle 30 → all outputs 0 immediately; no pop at 37. A `start` after release → first pop 5 cycles later.
- **Restart from DONE:** `start` at cycle 60 → `done`=0 at 61, first pop at 65, `level`=0 in cycles 61–64.
- **Default parameters:** check only that the first `pop` lands at cycle 100000001 and the second 300000000 cycles later.
